// File: rtl/cam_pkg.sv
// cam_pkg: shared constants for the cam_lru_free block.
//   CAM_DATA_WIDTH  default entry width in bits
//   CAM_DEPTH_LOG2  default log2 of the entry count
//   CAM_DEPTH       default entry count, derived from CAM_DEPTH_LOG2
//   cam_depth()     entry count for any log2 depth
package cam_pkg;

  localparam int CAM_DATA_WIDTH = 32;
  localparam int CAM_DEPTH_LOG2 = 5;

  function automatic int cam_depth(input int depth_log2);
    return 1 << depth_log2;
  endfunction

  localparam int CAM_DEPTH = cam_depth(CAM_DEPTH_LOG2);

endpackage

// File: rtl/cam_prienc.sv
// cam_prienc: lowest-index priority encoder with an any-hit flag.
//   req_i  [2**N_LOG2]  request vector, bit 0 has highest priority
//   hit_o               at least one request bit set
//   idx_o  [N_LOG2]     index of the lowest set bit, 0 when hit_o=0
module cam_prienc
  import cam_pkg::*;
#(
  parameter int N_LOG2 = CAM_DEPTH_LOG2
) (
  input  logic [cam_depth(N_LOG2)-1:0] req_i,
  output logic                         hit_o,
  output logic [N_LOG2-1:0]            idx_o
);

  localparam int N = cam_depth(N_LOG2);

  // Scanning downwards lets the lowest set bit be the last assignment.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        hit_o = 1'b1;
        idx_o = i[N_LOG2-1:0];
      end
    end
  end

endmodule

// File: rtl/cam_lru_free.sv
// cam_lru_free: small CAM with indexed write, insert-to-lowest-free-slot,
// invalidate, registered read and registered associative search.
//   clk, reset                        clock, synchronous active-low reset
//   write_i/_index_i/_data_i          indexed write (sets valid)
//   insert_i                          write write_data_i to lowest free entry
//   invalidate_i/_index_i             clear one valid bit
//   read_i/_index_i -> read_valid_o, read_value_o            (1 cycle later)
//   search_i/_data_i -> search_done_o/_valid_o/_multi_o/_index_o (1 cycle later)
//   insert_ack_o, insert_index_o      insert result (1 cycle later)
//   count_o, full_o, empty_o          occupancy after each edge
module cam_lru_free
  import cam_pkg::*;
#(
  parameter int DATA_WIDTH = CAM_DATA_WIDTH,
  parameter int DEPTH_LOG2 = CAM_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write_i,
  input  logic [DEPTH_LOG2-1:0] write_index_i,
  input  logic [DATA_WIDTH-1:0] write_data_i,
  input  logic                  insert_i,
  input  logic                  invalidate_i,
  input  logic [DEPTH_LOG2-1:0] invalidate_index_i,
  input  logic                  read_i,
  input  logic [DEPTH_LOG2-1:0] read_index_i,
  output logic                  read_valid_o,
  output logic [DATA_WIDTH-1:0] read_value_o,
  input  logic                  search_i,
  input  logic [DATA_WIDTH-1:0] search_data_i,
  output logic                  search_done_o,
  output logic                  search_valid_o,
  output logic                  search_multi_o,
  output logic [DEPTH_LOG2-1:0] search_index_o,
  output logic                  insert_ack_o,
  output logic [DEPTH_LOG2-1:0] insert_index_o,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int DEPTH = cam_depth(DEPTH_LOG2);

  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;

  logic [DEPTH-1:0]      match_vec;
  logic                  match_hit, free_hit;
  logic [DEPTH_LOG2-1:0] match_idx, free_idx;
  logic                  match_multi;
  logic                  ins_ok;

  logic                  read_valid_q, read_valid_d;
  logic [DATA_WIDTH-1:0] read_value_q, read_value_d;
  logic                  search_done_q, search_valid_q, search_multi_q;
  logic [DEPTH_LOG2-1:0] search_index_q, search_index_d;
  logic                  insert_ack_q;
  logic [DEPTH_LOG2-1:0] insert_index_q, insert_index_d;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      match_vec[i] = valid_q[i] && (data_q[i] == search_data_i);
    end
  end

  cam_prienc #(.N_LOG2(DEPTH_LOG2)) u_match_enc (
    .req_i (match_vec),
    .hit_o (match_hit),
    .idx_o (match_idx)
  );

  cam_prienc #(.N_LOG2(DEPTH_LOG2)) u_free_enc (
    .req_i (~valid_q),
    .hit_o (free_hit),
    .idx_o (free_idx)
  );

  // Clearing the lowest set bit leaves something only if two or more matched.
  assign match_multi = |(match_vec & (match_vec - DEPTH'(1)));

  assign ins_ok = insert_i && !write_i && !full_o && free_hit;

  // Invalidate first so a same-entry write/insert wins.
  always_comb begin
    valid_d = valid_q;
    if (invalidate_i) valid_d[invalidate_index_i] = 1'b0;
    if (write_i)      valid_d[write_index_i]      = 1'b1;
    if (ins_ok)       valid_d[free_idx]           = 1'b1;
    count_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count_d = count_d + (DEPTH_LOG2 + 1)'(valid_d[i]);
    end
  end

  always_comb begin
    read_valid_d   = read_i && valid_q[read_index_i];
    read_value_d   = read_valid_d ? data_q[read_index_i] : '0;
    search_index_d = (search_i && match_hit) ? match_idx : '0;
    insert_index_d = ins_ok ? free_idx : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q        <= '0;
      count_q        <= '0;
      read_valid_q   <= 1'b0;
      read_value_q   <= '0;
      search_done_q  <= 1'b0;
      search_valid_q <= 1'b0;
      search_multi_q <= 1'b0;
      search_index_q <= '0;
      insert_ack_q   <= 1'b0;
      insert_index_q <= '0;
    end else begin
      valid_q        <= valid_d;
      count_q        <= count_d;
      read_valid_q   <= read_valid_d;
      read_value_q   <= read_value_d;
      search_done_q  <= search_i;
      search_valid_q <= search_i && match_hit;
      search_multi_q <= search_i && match_multi;
      search_index_q <= search_index_d;
      insert_ack_q   <= ins_ok;
      insert_index_q <= insert_index_d;
    end
  end

  // Entry data is never cleared; it is only observable through valid bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (write_i) data_q[write_index_i] <= write_data_i;
      if (ins_ok)  data_q[free_idx]      <= write_data_i;
    end
  end

  assign read_valid_o   = read_valid_q;
  assign read_value_o   = read_value_q;
  assign search_done_o  = search_done_q;
  assign search_valid_o = search_valid_q;
  assign search_multi_o = search_multi_q;
  assign search_index_o = search_index_q;
  assign insert_ack_o   = insert_ack_q;
  assign insert_index_o = insert_index_q;
  assign count_o        = count_q;
  assign full_o         = (count_q == (DEPTH_LOG2 + 1)'(DEPTH));
  assign empty_o        = (count_q == '0);

endmodule

// File: tb/tb_cam_lru_free.sv
// tb_cam_lru_free: directed scenarios plus randomized traffic for cam_lru_free.
// Each issued cycle pushes the expected post-edge outputs into a queue; a
// monitor on the falling edge pops and compares them.
module tb_cam_lru_free;

  localparam int DW = 8;
  localparam int DL = 3;
  localparam int DEPTH = 1 << DL;

  logic          clk;
  logic          reset;
  logic          write_i;
  logic [DL-1:0] write_index_i;
  logic [DW-1:0] write_data_i;
  logic          insert_i;
  logic          invalidate_i;
  logic [DL-1:0] invalidate_index_i;
  logic          read_i;
  logic [DL-1:0] read_index_i;
  logic          read_valid_o;
  logic [DW-1:0] read_value_o;
  logic          search_i;
  logic [DW-1:0] search_data_i;
  logic          search_done_o, search_valid_o, search_multi_o;
  logic [DL-1:0] search_index_o;
  logic          insert_ack_o;
  logic [DL-1:0] insert_index_o;
  logic [DL:0]   count_o;
  logic          full_o, empty_o;

  cam_lru_free #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL)) dut (
    .clk                (clk),
    .reset              (reset),
    .write_i            (write_i),
    .write_index_i      (write_index_i),
    .write_data_i       (write_data_i),
    .insert_i           (insert_i),
    .invalidate_i       (invalidate_i),
    .invalidate_index_i (invalidate_index_i),
    .read_i             (read_i),
    .read_index_i       (read_index_i),
    .read_valid_o       (read_valid_o),
    .read_value_o       (read_value_o),
    .search_i           (search_i),
    .search_data_i      (search_data_i),
    .search_done_o      (search_done_o),
    .search_valid_o     (search_valid_o),
    .search_multi_o     (search_multi_o),
    .search_index_o     (search_index_o),
    .insert_ack_o       (insert_ack_o),
    .insert_index_o     (insert_index_o),
    .count_o            (count_o),
    .full_o             (full_o),
    .empty_o            (empty_o)
  );

  typedef struct {
    int            cyc;
    logic          ack;
    logic [DL-1:0] aidx;
    logic          rv;
    logic [DW-1:0] rval;
    logic          sd, sv, sm;
    logic [DL-1:0] sidx;
    logic [DL:0]   cnt;
    logic          full, empty;
  } exp_t;

  exp_t          expq[$];
  int            cyc = 0;
  int            tests = 0;
  int            fails = 0;
  logic [DW-1:0] mm [DEPTH];
  bit            mv [DEPTH];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (expq.size() > 0 && expq[0].cyc <= cyc) begin
      e = expq.pop_front();
      cmp("insert_ack",   insert_ack_o,   e.ack);
      cmp("insert_index", insert_index_o, e.aidx);
      cmp("read_valid",   read_valid_o,   e.rv);
      cmp("read_value",   read_value_o,   e.rval);
      cmp("search_done",  search_done_o,  e.sd);
      cmp("search_valid", search_valid_o, e.sv);
      cmp("search_index", search_index_o, e.sidx);
      cmp("search_multi", search_multi_o, e.sm);
      cmp("count",        count_o,        e.cnt);
      cmp("full",         full_o,         e.full);
      cmp("empty",        empty_o,        e.empty);
    end
  end

  function automatic int occupancy();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) n += mv[i] ? 1 : 0;
    return n;
  endfunction

  task automatic clear_ops();
    reset = 1'b1;
    write_i = 1'b0; write_index_i = '0; write_data_i = '0;
    insert_i = 1'b0;
    invalidate_i = 1'b0; invalidate_index_i = '0;
    read_i = 1'b0; read_index_i = '0;
    search_i = 1'b0; search_data_i = '0;
  endtask

  // Predict the outputs after the coming edge, advance the model, then clock.
  task automatic cycle();
    exp_t e;
    int   n, first, nm, fi;
    e.cyc = cyc + 1;
    e.ack = 0; e.aidx = '0; e.rv = 0; e.rval = '0;
    e.sd = 0; e.sv = 0; e.sm = 0; e.sidx = '0;
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mv[i] = 0;
    end else begin
      n  = occupancy();
      fi = 0;
      e.ack = insert_i && !write_i && (n < DEPTH);
      if (e.ack) begin
        for (int i = 0; i < DEPTH; i++) if (!mv[i]) begin fi = i; break; end
        e.aidx = DL'(fi);
      end
      e.rv   = read_i && mv[read_index_i];
      e.rval = e.rv ? mm[read_index_i] : '0;
      nm = 0; first = 0;
      for (int i = 0; i < DEPTH; i++) begin
        if (mv[i] && mm[i] == search_data_i) begin
          if (nm == 0) first = i;
          nm++;
        end
      end
      e.sd   = search_i;
      e.sv   = search_i && (nm > 0);
      e.sidx = e.sv ? DL'(first) : '0;
      e.sm   = search_i && (nm >= 2);
      if (invalidate_i) mv[invalidate_index_i] = 0;
      if (write_i) begin mm[write_index_i] = write_data_i; mv[write_index_i] = 1; end
      if (e.ack) begin mm[fi] = write_data_i; mv[fi] = 1; end
    end
    n       = occupancy();
    e.cnt   = (DL + 1)'(n);
    e.full  = (n == DEPTH);
    e.empty = (n == 0);
    expq.push_back(e);
    @(posedge clk);
    #1;
    clear_ops();
  endtask

  initial begin
    clear_ops();
    reset = 1'b0; cycle();
    reset = 1'b0; cycle();
    cmp("dir_reset_count", count_o, 0);
    cmp("dir_reset_empty", empty_o, 1);

    insert_i = 1; write_data_i = 8'h0A; cycle();
    cmp("dir_ins_a_ack", insert_ack_o, 1);
    cmp("dir_ins_a_idx", insert_index_o, 0);
    insert_i = 1; write_data_i = 8'h0B; cycle();
    cmp("dir_ins_b_idx", insert_index_o, 1);
    insert_i = 1; write_data_i = 8'h0C; cycle();
    cmp("dir_ins_c_idx", insert_index_o, 2);
    cmp("dir_count3", count_o, 3);

    write_i = 1; write_index_i = 5; write_data_i = 8'h0A; cycle();
    search_i = 1; search_data_i = 8'h0A; cycle();
    cmp("dir_dup_done",  search_done_o, 1);
    cmp("dir_dup_valid", search_valid_o, 1);
    cmp("dir_dup_index", search_index_o, 0);
    cmp("dir_dup_multi", search_multi_o, 1);

    write_i = 1; write_index_i = 3; write_data_i = 8'h55;
    read_i = 1; read_index_i = 3; search_i = 1; search_data_i = 8'h55; cycle();
    cmp("dir_nobypass_rv", read_valid_o, 0);
    cmp("dir_nobypass_sv", search_valid_o, 0);
    cmp("dir_nobypass_sd", search_done_o, 1);
    read_i = 1; read_index_i = 3; cycle();
    cmp("dir_after_rv",   read_valid_o, 1);
    cmp("dir_after_rval", read_value_o, 8'h55);

    write_i = 1; write_index_i = 1; write_data_i = 8'h77;
    invalidate_i = 1; invalidate_index_i = 1; cycle();
    read_i = 1; read_index_i = 1; cycle();
    cmp("dir_wr_inv_rv",   read_valid_o, 1);
    cmp("dir_wr_inv_rval", read_value_o, 8'h77);
    invalidate_i = 1; invalidate_index_i = 7; cycle();
    cmp("dir_inv_free_count", count_o, 5);

    insert_i = 1; write_data_i = 8'hE1; cycle();
    cmp("dir_fill_idx4", insert_index_o, 4);
    insert_i = 1; write_data_i = 8'hE2; cycle();
    cmp("dir_fill_idx6", insert_index_o, 6);
    insert_i = 1; write_data_i = 8'hE3; cycle();
    cmp("dir_fill_idx7", insert_index_o, 7);
    cmp("dir_full", full_o, 1);
    insert_i = 1; write_data_i = 8'hE4; cycle();
    cmp("dir_full_ack",   insert_ack_o, 0);
    cmp("dir_full_flag",  full_o, 1);
    cmp("dir_full_count", count_o, 8);
    invalidate_i = 1; invalidate_index_i = 2; cycle();
    insert_i = 1; write_data_i = 8'h0D; cycle();
    cmp("dir_refill_ack", insert_ack_o, 1);
    cmp("dir_refill_idx", insert_index_o, 2);

    search_i = 1; search_data_i = 8'h0D; cycle();
    cmp("dir_pre_rst_done", search_done_o, 1);
    reset = 1'b0; insert_i = 1; write_data_i = 8'h99; cycle();
    cmp("dir_rst_done",  search_done_o, 0);
    cmp("dir_rst_empty", empty_o, 1);
    cmp("dir_rst_count", count_o, 0);
    cmp("dir_rst_ack",   insert_ack_o, 0);
    reset = 1'b0; search_i = 1; search_data_i = 8'h0D; cycle();
    cmp("dir_rst_same_done", search_done_o, 0);
    read_i = 1; read_index_i = 2; cycle();
    cmp("dir_rst_read_rv", read_valid_o, 0);

    for (int k = 0; k < 400; k++) begin
      reset              = ($urandom_range(0, 59) != 0);
      write_i            = ($urandom_range(0, 3) == 0);
      write_index_i      = DL'($urandom_range(0, DEPTH - 1));
      write_data_i       = DW'($urandom_range(0, 7));
      insert_i           = ($urandom_range(0, 2) == 0);
      invalidate_i       = ($urandom_range(0, 3) == 0);
      invalidate_index_i = DL'($urandom_range(0, DEPTH - 1));
      read_i             = ($urandom_range(0, 1) == 0);
      read_index_i       = DL'($urandom_range(0, DEPTH - 1));
      search_i           = ($urandom_range(0, 1) == 0);
      search_data_i      = DW'($urandom_range(0, 7));
      cycle();
    end

    cycle();
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (expq.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expected 0", expq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
